hello_tx_arbiter: RTL and testbench
===================================

Name: hello_tx_arbiter

Overview:
- Packet-granular arbiter merging three SRIO HELLO packet streams (srio_fifo, srio_dma, adi chain) onto the single SRIO core TX AXI-Stream port.
- Grants one requester per packet, locks the grant until TLAST, and re-arbitrates round-robin.
- Output is a one-deep registered stage; TID tags the source port so downstream logic and debug can attribute packets.

Parameters:
- DATA_W, 64, TDATA width (HELLO format, 8-byte beats).
- USER_W, 32, TUSER width (src/dest IDs), passed through unchanged.

Ports:
- AXIS_ACLK  in  1  single clock for all logic.
- AXIS_ARESET  in  1  reset, synchronous, active-high.
- S0_AXIS_TVALID / S1_AXIS_TVALID / S2_AXIS_TVALID  in  1 each  requester beat valid.
- S0_AXIS_TREADY / S1_AXIS_TREADY / S2_AXIS_TREADY  out  1 each  requester beat accepted.
- S0_AXIS_TDATA / S1_AXIS_TDATA / S2_AXIS_TDATA  in  DATA_W each  beat data.
- S0_AXIS_TLAST / S1_AXIS_TLAST / S2_AXIS_TLAST  in  1 each  last beat of packet.
- S0_AXIS_TUSER / S1_AXIS_TUSER / S2_AXIS_TUSER  in  USER_W each  sideband.
- M_AXIS_TVALID  out  1  output beat valid.
- M_AXIS_TREADY  in  1  SRIO core ready.
- M_AXIS_TDATA  out  DATA_W  output data.
- M_AXIS_TLAST  out  1  output last.
- M_AXIS_TUSER  out  USER_W  output sideband.
- M_AXIS_TID  out  2  source port of the current output beat (0..2).
- port_mask  in  3  bit i = 1 means port i is eligible for grant.
- busy  out  1  a grant is currently locked.
- cur_src  out  2  port holding the grant; valid when busy = 1.

Behaviour:
- Reset (AXIS_ARESET = 1 at a clock edge):
  - state goes to IDLE, last_grant = 2 (so port 0 is first in round-robin order), output register empty.
  - All S*_TREADY = 0. M_AXIS_TVALID = 0, TDATA = 0, TLAST = 0, TUSER = 0, TID = 0, busy = 0, cur_src = 0.
  - Reset mid-packet drops the in-flight packet and discards the output-register beat. No recovery is attempted.
- Output register:
  - full flag plus data, last, user and tid registers.
  - Accept condition: acc = !full | M_AXIS_TREADY.
  - M_AXIS_TVALID = full.
  - When a beat is popped and a new beat is loaded in the same cycle, full stays 1 and the data is replaced.
- FSM state IDLE:
  - All S*_TREADY = 0.
  - req = {S2,S1,S0}_TVALID & port_mask.
  - If req != 0, choose the first set bit searching last_grant+1, +2, +3 (mod 3). Register it into cur_src and enter LOCK.
  - Arbitration costs exactly one cycle; no beat is accepted in the decision cycle.
- FSM state LOCK:
  - Only the granted port sees TREADY: S[cur_src]_TREADY = acc (combinational from M_AXIS_TREADY). Other ports have TREADY = 0.
  - On an accepted beat, load the output register with that beat and set tid = cur_src.
  - An accepted beat with TLAST = 1 sets last_grant = cur_src and returns to IDLE.
- Packet-to-packet gap: at least one cycle, spent in IDLE. Back-to-back packets from the same port are legal if no other port is requesting.
- port_mask changes:
  - Sampled only in IDLE.
  - Clearing the mask bit of the locked port does not abort its packet; the grant holds until TLAST.
- Requester TVALID deasserting mid-packet: the grant holds and the arbiter waits indefinitely (no timeout).
- A single-beat packet (TLAST on the first beat) is legal: one beat in LOCK, then IDLE.
- busy = (state == LOCK). cur_src is held after the return to IDLE.
- Throughput: one beat per cycle while the requester is valid and M_AXIS_TREADY = 1.
- Latency: a beat accepted at cycle n is visible on M at cycle n+1.
- Data integrity: no reordering and no interleaving within a packet. TDATA and TUSER pass through unmodified.

Optional Feature:
- Macro: HELLO_TX_ARB_PRIO0_EN.
- Defined: port 0 (maintenance/response traffic) has strict priority at each arbitration point. If req[0] = 1, grant port 0; otherwise apply round-robin between ports 1 and 2. last_grant is updated only by port 1/2 grants.
- Undefined: pure 3-way round-robin as above.
- A locked grant is never pre-empted in either mode.

Decomposition:
- Package hello_pkg holds:
  - localparams ST_IDLE / ST_LOCK;
  - NUM_SRC = 3;
  - port index constants SRC_FIFO = 0, SRC_DMA = 1, SRC_ADI = 2;
  - a function rr_next(req[2:0], last[1:0]) returning the 2-bit grant.
- One natural sub-module: hello_axis_reg, the one-deep output register (full flag, acc generation, data/last/user/tid storage).
- Arbitration and the FSM stay in the top module.

Test Plan:
- Reset, then S1 sends a 3-beat packet (TDATA 0x11..0x13, TUSER 0xA5A5_0001), port_mask = 3'b111, M_AXIS_TREADY = 1 → M emits 0x11, 0x12, 0x13 on consecutive cycles with TID = 1 and TLAST on 0x13; busy falls the cycle after the last accept.
- S0, S1 and S2 all continuously offering 2-beat packets → grant order 0, 1, 2, 0, 1, 2; each packet contiguous; exactly one IDLE cycle between packets.
- S2 mid-packet (beat 2 of 4) while S0 asserts TVALID → S0_TREADY stays 0 until S2's TLAST beat is accepted; S0 granted next.
- M_AXIS_TREADY toggled 1, 0, 0, 1 during a 4-beat S0 packet → no beat lost or duplicated, M_AXIS_TDATA stable while TVALID = 1 and TREADY = 0, S0_TREADY = 0 in the stalled cycles once the register is full.
- port_mask = 3'b101 with all ports requesting → port 1 never granted. Clear bit 0 during an S0 packet → that packet completes, then S0 is not re-granted.
- AXIS_ARESET pulsed on beat 2 of a 5-beat S1 packet → next cycle M_AXIS_TVALID = 0, busy = 0, all TREADY = 0. With HELLO_TX_ARB_PRIO0_EN defined and all ports requesting → port 0 wins every arbitration.

Source files
------------

// File: rtl/hello_pkg.sv
// hello_pkg: shared state encoding, source indices and round-robin helper for hello_tx_arbiter
package hello_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_LOCK = 1'b1} state_t;
  localparam int NUM_SRC = 3;
  localparam logic [1:0] SRC_FIFO = 2'd0;
  localparam logic [1:0] SRC_DMA = 2'd1;
  localparam logic [1:0] SRC_ADI = 2'd2;
  function automatic logic [1:0] inc3(input logic [1:0] i);
    return i == SRC_ADI ? SRC_FIFO : i + 2'd1;
  endfunction
  function automatic logic [1:0] rr_next(input logic [2:0] req, input logic [1:0] last);
    logic [1:0] a, b, c;
    a = inc3(last);
    b = inc3(a);
    c = inc3(b);
    return req[a] ? a : req[b] ? b : c;
  endfunction
endpackage

// File: rtl/hello_tx_arbiter_if.sv
// hello_tx_arbiter_if: AXI-Stream beat bundle; tid is only carried on the merged output side
interface hello_tx_arbiter_if #(parameter int DATA_W = 64, parameter int USER_W = 32);
  logic tvalid;
  logic tready;
  logic tlast;
  logic [DATA_W-1:0] tdata;
  logic [USER_W-1:0] tuser;
  logic [1:0] tid;
  modport master (output tvalid, tdata, tlast, tuser, tid, input tready);
  modport slave (input tvalid, tdata, tlast, tuser, output tready);
endinterface

// File: rtl/hello_axis_reg.sv
// hello_axis_reg: one-deep registered AXI-Stream output stage with accept generation
module hello_axis_reg #(parameter int DATA_W = 64, parameter int USER_W = 32) (
  input  logic clk,
  input  logic rst,
  input  logic ld,
  input  logic [DATA_W-1:0] d_data,
  input  logic d_last,
  input  logic [USER_W-1:0] d_user,
  input  logic [1:0] d_tid,
  output logic acc,
  hello_tx_arbiter_if.master m
);
  logic full;
  logic last;
  logic [DATA_W-1:0] data;
  logic [USER_W-1:0] user;
  logic [1:0] tid;
  assign acc = !full || m.tready;
  assign m.tvalid = full;
  assign m.tdata = data;
  assign m.tlast = last;
  assign m.tuser = user;
  assign m.tid = tid;
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      last <= 1'b0;
      data <= '0;
      user <= '0;
      tid <= '0;
    end else begin
      full <= ld || (full && !m.tready);
      if (ld) begin
        data <= d_data;
        last <= d_last;
        user <= d_user;
        tid <= d_tid;
      end
    end
  end
endmodule

// File: rtl/hello_tx_arbiter.sv
// hello_tx_arbiter: packet-granular round-robin merge of three HELLO streams onto one AXI-Stream
// HELLO_TX_ARB_PRIO0_EN gives port 0 strict priority at each arbitration point
module hello_tx_arbiter import hello_pkg::*; #(parameter int DATA_W = 64, parameter int USER_W = 32) (
  input  logic AXIS_ACLK,
  input  logic AXIS_ARESET,
  hello_tx_arbiter_if.slave s0_axis,
  hello_tx_arbiter_if.slave s1_axis,
  hello_tx_arbiter_if.slave s2_axis,
  hello_tx_arbiter_if.master m_axis,
  input  logic [2:0] port_mask,
  output logic busy,
  output logic [1:0] cur_src
);
  state_t state, state_nxt;
  logic [1:0] last_grant, last_nxt, cur_nxt, grant;
  logic [2:0] req;
  logic acc, ld, sel_valid, sel_last;
  logic [DATA_W-1:0] sel_data;
  logic [USER_W-1:0] sel_user;
  assign req = {s2_axis.tvalid, s1_axis.tvalid, s0_axis.tvalid} & port_mask;
`ifdef HELLO_TX_ARB_PRIO0_EN
  assign grant = req[SRC_FIFO] ? SRC_FIFO : rr_next(req & 3'b110, last_grant);
`else
  assign grant = rr_next(req, last_grant);
`endif
  assign sel_valid = cur_src == SRC_ADI ? s2_axis.tvalid : cur_src == SRC_DMA ? s1_axis.tvalid : s0_axis.tvalid;
  assign sel_last = cur_src == SRC_ADI ? s2_axis.tlast : cur_src == SRC_DMA ? s1_axis.tlast : s0_axis.tlast;
  assign sel_data = cur_src == SRC_ADI ? s2_axis.tdata : cur_src == SRC_DMA ? s1_axis.tdata : s0_axis.tdata;
  assign sel_user = cur_src == SRC_ADI ? s2_axis.tuser : cur_src == SRC_DMA ? s1_axis.tuser : s0_axis.tuser;
  assign busy = state == ST_LOCK;
  assign ld = busy && sel_valid && acc;
  assign s0_axis.tready = busy && cur_src == SRC_FIFO && acc;
  assign s1_axis.tready = busy && cur_src == SRC_DMA && acc;
  assign s2_axis.tready = busy && cur_src == SRC_ADI && acc;
  always_comb begin
    state_nxt = busy ? (ld && sel_last ? ST_IDLE : ST_LOCK) : (|req ? ST_LOCK : ST_IDLE);
    cur_nxt = !busy && |req ? grant : cur_src;
`ifdef HELLO_TX_ARB_PRIO0_EN
    last_nxt = ld && sel_last && cur_src != SRC_FIFO ? cur_src : last_grant;
`else
    last_nxt = ld && sel_last ? cur_src : last_grant;
`endif
  end
  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      state <= ST_IDLE;
      cur_src <= SRC_FIFO;
      last_grant <= SRC_ADI;
    end else begin
      state <= state_nxt;
      cur_src <= cur_nxt;
      last_grant <= last_nxt;
    end
  end
  hello_axis_reg #(.DATA_W(DATA_W), .USER_W(USER_W)) u_out (
    .clk(AXIS_ACLK),
    .rst(AXIS_ARESET),
    .ld(ld),
    .d_data(sel_data),
    .d_last(sel_last),
    .d_user(sel_user),
    .d_tid(cur_src),
    .acc(acc),
    .m(m_axis)
  );
endmodule

// File: tb/tb_hello_tx_arbiter.sv
// tb_hello_tx_arbiter: directed checks of grant order, packet locking, stalls, masking and reset
module tb_hello_tx_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] port_mask;
  logic busy;
  logic [1:0] cur_src;
  hello_tx_arbiter_if #(.DATA_W(64), .USER_W(32)) s0 ();
  hello_tx_arbiter_if #(.DATA_W(64), .USER_W(32)) s1 ();
  hello_tx_arbiter_if #(.DATA_W(64), .USER_W(32)) s2 ();
  hello_tx_arbiter_if #(.DATA_W(64), .USER_W(32)) m ();
  hello_tx_arbiter #(.DATA_W(64), .USER_W(32)) dut (
    .AXIS_ACLK(clk),
    .AXIS_ARESET(rst),
    .s0_axis(s0),
    .s1_axis(s1),
    .s2_axis(s2),
    .m_axis(m),
    .port_mask(port_mask),
    .busy(busy),
    .cur_src(cur_src)
  );
  always #5 clk = ~clk;
  int vectors = 0;
  int miss = 0;
  int ncyc;
  logic [63:0] base [3];
  logic [31:0] usr [3];
  int len [3];
  int left [3];
  int beat [3];
  int pk [3];
  logic [63:0] oq_d [$];
  logic oq_l [$];
  logic [1:0] oq_t [$];
  logic [1:0] gq [$];
`ifdef HELLO_TX_ARB_PRIO0_EN
  int ge2 [6] = '{0, 0, 1, 2, 1, 2};
  int ge5 [4] = '{0, 0, 2, 2};
`else
  int ge2 [6] = '{0, 1, 2, 0, 1, 2};
  int ge5 [4] = '{2, 0, 2, 0};
`endif
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drv;
    s0.tvalid = left[0] > 0;
    s0.tdata = base[0] + 64'(pk[0] * 16 + beat[0]);
    s0.tlast = beat[0] == len[0] - 1;
    s0.tuser = usr[0];
    s1.tvalid = left[1] > 0;
    s1.tdata = base[1] + 64'(pk[1] * 16 + beat[1]);
    s1.tlast = beat[1] == len[1] - 1;
    s1.tuser = usr[1];
    s2.tvalid = left[2] > 0;
    s2.tdata = base[2] + 64'(pk[2] * 16 + beat[2]);
    s2.tlast = beat[2] == len[2] - 1;
    s2.tuser = usr[2];
  endtask
  task automatic src(input int p, input logic [63:0] b, input int l, input int n);
    base[p] = b;
    len[p] = l;
    left[p] = n;
    beat[p] = 0;
    pk[p] = 0;
    usr[p] = 32'hA5A5_0000 | 32'(p);
  endtask
  task automatic clr;
    oq_d.delete();
    oq_l.delete();
    oq_t.delete();
    gq.delete();
  endtask
  task automatic cyc;
    logic [2:0] h;
    logic pb;
    #1;
    h = {s2.tvalid & s2.tready, s1.tvalid & s1.tready, s0.tvalid & s0.tready};
    pb = busy;
    if (m.tvalid && m.tready) begin
      oq_d.push_back(m.tdata);
      oq_l.push_back(m.tlast);
      oq_t.push_back(m.tid);
    end
    @(posedge clk);
    #1;
    if (busy && !pb) gq.push_back(cur_src);
    for (int p = 0; p < 3; p++)
      if (h[p]) begin
        if (beat[p] == len[p] - 1) begin
          beat[p] = 0;
          pk[p]++;
          left[p]--;
        end else beat[p]++;
      end
    drv;
    #1;
  endtask
  task automatic run(input logic [2:0] w);
    int n = 0;
    while (((w[0] && left[0] > 0) || (w[1] && left[1] > 0) || (w[2] && left[2] > 0) || busy || m.tvalid) && n < 200) begin
      cyc;
      n++;
    end
    ncyc = n;
    chk("run_bound", 64'(n < 200), 64'd1);
  endtask
  task automatic do_reset;
    rst = 1'b1;
    for (int p = 0; p < 3; p++) left[p] = 0;
    drv;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int cnt [3];
    int k;
    port_mask = 3'b111;
    m.tready = 1'b1;
    for (int p = 0; p < 3; p++) src(p, 64'h0, 1, 0);
    drv;
    do_reset;
    chk("rst_tvalid", m.tvalid, 0);
    chk("rst_tdata", m.tdata, 0);
    chk("rst_tlast", m.tlast, 0);
    chk("rst_tuser", m.tuser, 0);
    chk("rst_tid", m.tid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cur_src", cur_src, 0);
    chk("rst_tready", {s2.tready, s1.tready, s0.tready}, 0);
    src(1, 64'h11, 3, 1);
    drv;
    #1;
    chk("t1_idle_ready", s1.tready, 0);
    cyc;
    chk("t1_busy", busy, 1);
    chk("t1_cur_src", cur_src, 1);
    chk("t1_s1_ready", s1.tready, 1);
    chk("t1_s0_ready", s0.tready, 0);
    chk("t1_decision_empty", m.tvalid, 0);
    cyc;
    chk("t1_b0_valid", m.tvalid, 1);
    chk("t1_b0_data", m.tdata, 64'h11);
    chk("t1_b0_tid", m.tid, 1);
    chk("t1_b0_last", m.tlast, 0);
    chk("t1_b0_user", m.tuser, 32'hA5A5_0001);
    cyc;
    chk("t1_b1_data", m.tdata, 64'h12);
    cyc;
    chk("t1_b2_data", m.tdata, 64'h13);
    chk("t1_b2_last", m.tlast, 1);
    chk("t1_busy_fall", busy, 0);
    cyc;
    chk("t1_drained", m.tvalid, 0);
    do_reset;
    clr;
    for (int p = 0; p < 3; p++) src(p, 64'(p) * 256, 2, 2);
    drv;
    run(3'b111);
    chk("t2_cycles", ncyc, 19);
    chk("t2_grants", gq.size(), 6);
    chk("t2_beats", oq_d.size(), 12);
    for (int p = 0; p < 3; p++) cnt[p] = 0;
    for (int i = 0; i < 6 && i < gq.size(); i++) begin
      chk($sformatf("t2_grant%0d", i), gq[i], ge2[i]);
      for (int b = 0; b < 2; b++) begin
        k = i * 2 + b;
        if (k < oq_d.size()) begin
          chk($sformatf("t2_data%0d", k), oq_d[k], 64'(ge2[i]) * 256 + 64'(cnt[ge2[i]] * 16 + b));
          chk($sformatf("t2_tid%0d", k), oq_t[k], ge2[i]);
          chk($sformatf("t2_last%0d", k), oq_l[k], b == 1);
        end
      end
      cnt[ge2[i]]++;
    end
    clr;
    src(2, 64'h20, 4, 1);
    drv;
    cyc;
    cyc;
    cyc;
    src(0, 64'h30, 2, 1);
    drv;
    #1;
    chk("t3_hold_src", cur_src, 2);
    chk("t3_s0_blocked_a", s0.tready, 0);
    cyc;
    chk("t3_s0_blocked_b", s0.tready, 0);
    cyc;
    chk("t3_s0_blocked_c", s0.tready, 0);
    chk("t3_idle_gap", busy, 0);
    cyc;
    chk("t3_s0_granted", cur_src, 0);
    chk("t3_s0_ready", s0.tready, 1);
    run(3'b111);
    chk("t3_beats", oq_d.size(), 6);
    for (int i = 0; i < 6 && i < oq_d.size(); i++)
      chk($sformatf("t3_data%0d", i), oq_d[i], i < 4 ? 64'h20 + 64'(i) : 64'h30 + 64'(i - 4));
    clr;
    src(0, 64'h40, 4, 1);
    drv;
    cyc;
    cyc;
    m.tready = 1'b0;
    #1;
    chk("t4_stall_ready_a", s0.tready, 0);
    chk("t4_stall_valid", m.tvalid, 1);
    chk("t4_stall_data_a", m.tdata, 64'h40);
    cyc;
    chk("t4_stall_data_b", m.tdata, 64'h40);
    chk("t4_stall_ready_b", s0.tready, 0);
    cyc;
    m.tready = 1'b1;
    run(3'b111);
    chk("t4_beats", oq_d.size(), 4);
    for (int i = 0; i < 4 && i < oq_d.size(); i++) begin
      chk($sformatf("t4_data%0d", i), oq_d[i], 64'h40 + 64'(i));
      chk($sformatf("t4_last%0d", i), oq_l[i], i == 3);
    end
    clr;
    port_mask = 3'b101;
    for (int p = 0; p < 3; p++) src(p, 64'h0, 1, 2);
    drv;
    run(3'b101);
    chk("t5_grants", gq.size(), 4);
    for (int i = 0; i < 4 && i < gq.size(); i++) chk($sformatf("t5_grant%0d", i), gq[i], ge5[i]);
    chk("t5_s1_untouched", left[1], 2);
    clr;
    src(0, 64'h50, 3, 2);
    drv;
    cyc;
    cyc;
    port_mask = 3'b100;
    repeat (8) cyc;
    chk("t5_mask_left", left[0], 1);
    chk("t5_mask_idle", busy, 0);
    chk("t5_mask_grants", gq.size(), 1);
    chk("t5_mask_beats", oq_d.size(), 3);
    if (oq_d.size() == 3) chk("t5_mask_lastdata", oq_d[2], 64'h52);
    port_mask = 3'b111;
    run(3'b011);
    clr;
    src(1, 64'h60, 5, 1);
    drv;
    cyc;
    cyc;
    cyc;
    chk("t6_pre_data", m.tdata, 64'h61);
    chk("t6_pre_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("t6_tvalid", m.tvalid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_tready", {s2.tready, s1.tready, s0.tready}, 0);
    chk("t6_cur_src", cur_src, 0);
    cyc;
    chk("t6_regrant", cur_src, 1);
    chk("t6_regrant_busy", busy, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
